// File: rtl/spike_decoder_if.sv
// Bundle of spike-decoder stimulus and result signals.
// The bench or upstream neuron logic drives through master; the decoder attaches to slave.
interface spike_decoder_if #(
  parameter int CNT_W = 8
) ();
  logic             spike;
  logic             enable;
  logic [CNT_W-1:0] window_len;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic [CNT_W-1:0] isi;
  logic             isi_valid;
  logic             busy;

  modport master (
    output spike, enable, window_len,
    input  rate, rate_valid, isi, isi_valid, busy
  );

  modport slave (
    input  spike, enable, window_len,
    output rate, rate_valid, isi, isi_valid, busy
  );
endinterface

// File: rtl/spike_decoder.sv
// Spike-train decoder: windowed spike rate (gapless back-to-back windows)
// and last inter-spike interval, both as registered values with one-cycle valid pulses.
module spike_decoder #(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  spike_decoder_if.slave bus
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] win_len_q, win_len_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             rate_valid_q, rate_valid_d;
  logic [CNT_W-1:0] isi_cnt_q, isi_cnt_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] isi_q, isi_d;
  logic             isi_valid_q, isi_valid_d;

  logic [CNT_W-1:0] win_last;
  logic [CNT_W-1:0] spk_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A latched length of 0 wraps to all-ones here, i.e. a 2^CNT_W-cycle window.
  assign win_last = win_len_q - 1'b1;
  assign spk_next = bus.spike ? sat_inc(spk_cnt_q) : spk_cnt_q;

  always_comb begin
    state_d      = state_q;
    win_len_d    = win_len_q;
    cyc_d        = cyc_q;
    spk_cnt_d    = spk_cnt_q;
    rate_d       = rate_q;
    rate_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d   = COUNT;
          win_len_d = bus.window_len;
          cyc_d     = '0;
          spk_cnt_d = '0;
        end
      end
      COUNT: begin
        if (!bus.enable) begin
          state_d   = IDLE;
          cyc_d     = '0;
          spk_cnt_d = '0;
        end else if (cyc_q == win_last) begin
          // Window closes and the next one opens on the same edge.
          rate_d       = spk_next;
          rate_valid_d = 1'b1;
          win_len_d    = bus.window_len;
          cyc_d        = '0;
          spk_cnt_d    = '0;
        end else begin
          cyc_d     = cyc_q + 1'b1;
          spk_cnt_d = spk_next;
        end
      end
      default: begin
        state_d   = IDLE;
        cyc_d     = '0;
        spk_cnt_d = '0;
      end
    endcase
  end

  // ISI tracking runs on every enabled edge regardless of window state.
  always_comb begin
    isi_d       = isi_q;
    isi_valid_d = 1'b0;
    armed_d     = armed_q;
    isi_cnt_d   = isi_cnt_q;
    if (!bus.enable) begin
      armed_d   = 1'b0;
      isi_cnt_d = '0;
    end else if (bus.spike) begin
      if (armed_q) begin
        isi_d       = sat_inc(isi_cnt_q);
        isi_valid_d = 1'b1;
      end
      armed_d   = 1'b1;
      isi_cnt_d = '0;
    end else if (armed_q) begin
      isi_cnt_d = sat_inc(isi_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      win_len_q    <= '0;
      cyc_q        <= '0;
      spk_cnt_q    <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      isi_cnt_q    <= '0;
      armed_q      <= 1'b0;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_len_q    <= win_len_d;
      cyc_q        <= cyc_d;
      spk_cnt_q    <= spk_cnt_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      isi_cnt_q    <= isi_cnt_d;
      armed_q      <= armed_d;
      isi_q        <= isi_d;
      isi_valid_q  <= isi_valid_d;
    end
  end

  assign bus.rate       = rate_q;
  assign bus.rate_valid = rate_valid_q;
  assign bus.isi        = isi_q;
  assign bus.isi_valid  = isi_valid_q;
  assign bus.busy       = (state_q == COUNT);

endmodule

// File: tb/tb_spike_decoder.sv
// Self-checking bench for spike_decoder: window-rate vector table, hand-written
// reset/ISI/abort sequences, and a pulse scoreboard keyed on expected clock edge.
module tb_spike_decoder;

  localparam int CNT_W = 8;

  typedef struct {
    logic [CNT_W-1:0] val;
    int               at_edge;
  } exp_t;

  typedef struct {
    logic [CNT_W-1:0] len;
    int               mode;      // 0 zeros, 1 ones, 2 alternating 1,0, 3 one every third
    int               nwin;
    logic [CNT_W-1:0] exp_rate;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   ecnt = 0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_rate = 1'b1;
  bit   chk_isi  = 1'b0;
  exp_t rq[$];
  exp_t iq[$];
  vec_t vecs[9];

  spike_decoder_if #(.CNT_W(CNT_W)) bus ();

  spike_decoder #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d edge=%0d", name, act, exp, ecnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pat(input int mode, input int j);
    case (mode)
      1:       return 1'b1;
      2:       return (j % 2) == 1;
      3:       return ((j - 1) % 3) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Pulse monitor: every valid pulse must match the head of its queue, value and edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_rate && bus.rate_valid) begin
        if (rq.size() == 0) chk("rate_valid_unexpected", 32'd1, 32'd0);
        else begin
          e = rq.pop_front();
          chk("rate_value", bus.rate, e.val);
          chk("rate_edge", ecnt, e.at_edge);
        end
      end
      if (chk_isi && bus.isi_valid) begin
        if (iq.size() == 0) chk("isi_valid_unexpected", 32'd1, 32'd0);
        else begin
          e = iq.pop_front();
          chk("isi_value", bus.isi, e.val);
          chk("isi_edge", ecnt, e.at_edge);
        end
      end
    end
  end

  initial begin
    int base;
    int n;
    vecs[0] = '{8'd10, 2, 2, 8'd5};
    vecs[1] = '{8'd0,  1, 1, 8'd255};
    vecs[2] = '{8'd4,  1, 3, 8'd4};
    vecs[3] = '{8'd7,  3, 2, 8'd3};
    vecs[4] = '{8'd1,  1, 3, 8'd1};
    vecs[5] = '{8'd1,  0, 2, 8'd0};
    vecs[6] = '{8'd3,  0, 1, 8'd0};
    vecs[7] = '{8'd5,  2, 2, 8'd3};
    vecs[8] = '{8'd255, 1, 1, 8'd255};

    // Reset held with spike and enable high: everything stays zero.
    reset_n = 1'b0;
    bus.spike = 1'b1;
    bus.enable = 1'b1;
    bus.window_len = 8'd5;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_rate", bus.rate, 0);
      chk("rst_isi", bus.isi, 0);
      chk("rst_rate_valid", bus.rate_valid, 0);
      chk("rst_isi_valid", bus.isi_valid, 0);
      chk("rst_busy", bus.busy, 0);
    end
    reset_n = 1'b1;
    tick();
    chk("first_edge_latch_busy", bus.busy, 1);
    bus.enable = 1'b0;
    tick();
    chk("abort_busy", bus.busy, 0);

    // Window-rate vector table.
    for (int v = 0; v < 9; v++) begin
      n = (vecs[v].len == 0) ? 256 : int'(vecs[v].len);
      bus.window_len = vecs[v].len;
      bus.enable = 1'b1;
      bus.spike = 1'b0;
      tick();
      chk("tbl_busy_latch", bus.busy, 1);
      for (int w = 0; w < vecs[v].nwin; w++) begin
        for (int j = 1; j <= n; j++) begin
          bus.spike = pat(vecs[v].mode, j);
          if (j == n) rq.push_back('{vecs[v].exp_rate, ecnt + 1});
          tick();
        end
        chk("tbl_busy_gapless", bus.busy, 1);
      end
      bus.enable = 1'b0;
      bus.spike = 1'b0;
      tick();
      chk("tbl_busy_idle", bus.busy, 0);
      chk("tbl_rate_hold", bus.rate, vecs[v].exp_rate);
    end

    // Length change mid-window takes effect only at the next window boundary.
    bus.window_len = 8'd4;
    bus.enable = 1'b1;
    bus.spike = 1'b1;
    tick();
    base = ecnt;
    rq.push_back('{8'd4, base + 4});
    rq.push_back('{8'd6, base + 10});
    rq.push_back('{8'd6, base + 16});
    for (int r = 1; r <= 16; r++) begin
      if (r == 3) bus.window_len = 8'd6;
      tick();
      chk("relen_busy", bus.busy, 1);
    end
    bus.enable = 1'b0;
    tick();

    // ISI: spikes at relative edges 3, 8, 400, 401; edge 0 also latches a 256-cycle window.
    chk_isi = 1'b1;
    bus.window_len = 8'd0;
    bus.enable = 1'b1;
    for (int r = 0; r <= 401; r++) begin
      bus.spike = (r == 3 || r == 8 || r == 400 || r == 401);
      if (r == 8)   iq.push_back('{8'd5, ecnt + 1});
      if (r == 400) iq.push_back('{8'd255, ecnt + 1});
      if (r == 401) iq.push_back('{8'd1, ecnt + 1});
      if (r == 256) rq.push_back('{8'd2, ecnt + 1});
      tick();
    end
    bus.enable = 1'b0;
    bus.spike = 1'b1;
    tick();
    chk("isi_hold_after_disable", bus.isi, 1);
    chk("isi_busy_after_abort", bus.busy, 0);
    tick();
    chk_isi = 1'b0;

    // Abort by enable drop on the 3rd COUNT edge: no rate update.
    bus.window_len = 8'd8;
    bus.enable = 1'b1;
    tick();
    tick();
    tick();
    bus.enable = 1'b0;
    tick();
    chk("abort_busy_next", bus.busy, 0);
    chk("abort_rate_kept", bus.rate, 2);
    for (int i = 0; i < 10; i++) tick();
    chk("abort_rate_still", bus.rate, 2);

    // Reset in the middle of a window clears everything and emits no pulse.
    bus.enable = 1'b1;
    tick();
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    chk("midrst_rate", bus.rate, 0);
    chk("midrst_isi", bus.isi, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_rate_valid", bus.rate_valid, 0);
    reset_n = 1'b1;
    bus.enable = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("midrst_rate_after", bus.rate, 0);

    chk("rate_queue_drained", rq.size(), 0);
    chk("isi_queue_drained", iq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
